// File: rtl/power_seq_ctrl_pkg.sv
// Shared definitions for the board power-rail sequencer.
// Contents:
//   state_e        FSM state encoding. It is also the debug encoding on o_state.
//   STATE_W        width of the o_state debug port.
//   max3()         largest of three delays, used to size the ms timer.
//   cnt_w_fits()   true when a CNT_W-bit timer can hold a given ms value.
package power_seq_ctrl_pkg;

  localparam int STATE_W    = 3;
  localparam int N_RAIL_MAX = 8;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE     = 3'd0,
    ST_ENABLE   = 3'd1,
    ST_WAIT_PG  = 3'd2,
    ST_STEP     = 3'd3,
    ST_HOLD_RST = 3'd4,
    ST_ON       = 3'd5,
    ST_SHUTDOWN = 3'd6,
    ST_FAULT    = 3'd7
  } state_e;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

  // The timer compares against the delays, so every delay must fit in the timer.
  // Saturation at all-ones is not a valid terminal count.
  function automatic bit cnt_w_fits(input int cnt_w, input int value);
    return (cnt_w >= 1) && (cnt_w <= 31) &&
           (longint'(value) < ((longint'(1) << cnt_w) - longint'(1)));
  endfunction

endpackage

// File: rtl/power_seq_ctrl_if.sv
// Request and rail bundle of the power sequencer.
// Signals:
//   i_pwr_req    1 = request power on, 0 = request power off
//   i_pg         per-rail power-good. These are asynchronous and are synchronised inside.
//   o_rail_en    rail enables. Bit k drives rail k.
//   o_sys_rst_n  system reset to downstream logic, active low
//   o_pwr_ok     high only while the rails are fully up (state ON)
//   o_fault      latched fault flag
//   o_state      FSM state, for debug
// Modports:
//   master  the board side that requests power and reports power-good
//   slave   the sequencer
interface power_seq_ctrl_if #(
  parameter int N_RAIL = 4
);
  import power_seq_ctrl_pkg::*;

  logic                 i_pwr_req;
  logic [N_RAIL-1:0]    i_pg;
  logic [N_RAIL-1:0]    o_rail_en;
  logic                 o_sys_rst_n;
  logic                 o_pwr_ok;
  logic                 o_fault;
  logic [STATE_W-1:0]   o_state;

  modport master (
    output i_pwr_req, i_pg,
    input  o_rail_en, o_sys_rst_n, o_pwr_ok, o_fault, o_state
  );

  modport slave (
    input  i_pwr_req, i_pg,
    output o_rail_en, o_sys_rst_n, o_pwr_ok, o_fault, o_state
  );

endinterface

// File: rtl/power_seq_ctrl_ms_tick_gen.sv
// 1 ms tick generator. Other 1 ms-timed blocks can reuse it.
// The divided 1 kHz clock is treated as plain data. It is synchronised into the
// system clock domain, and its rising edge becomes a single-cycle tick.
// Ports:
//   clk     system clock
//   rst_n   asynchronous active-low reset
//   clk_1k  1 kHz divided clock, asynchronous to clk
//   tick    registered one-cycle pulse per rising edge of clk_1k
module ms_tick_gen (
  input  logic clk,
  input  logic rst_n,
  input  logic clk_1k,
  output logic tick
);

  logic meta_r;
  logic sync_r;
  logic prev_r;
  logic tick_r;

  // Two-flop synchroniser, an edge-history flop and the registered tick pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_r <= 1'b0;
      sync_r <= 1'b0;
      prev_r <= 1'b0;
      tick_r <= 1'b0;
    end else begin
      meta_r <= clk_1k;
      sync_r <= meta_r;
      prev_r <= sync_r;
      tick_r <= sync_r & ~prev_r;
    end
  end

  assign tick = tick_r;

endmodule

// File: rtl/power_seq_ctrl.sv
// Board power-rail sequencer.
// Power-up: the rails are enabled in order. After each enable the block waits for
// that rail's power-good, then waits a settle delay before the next enable. After
// the last rail is good, system reset is held for T_RST_MS before release.
// Power-down: the rails are disabled in reverse order, one per T_STEP_MS.
// Faults: a power-good timeout or the loss of power-good on an enabled rail drops
// every rail at once. The fault stays latched until power is no longer requested.
// All delays count 1 ms ticks taken from the divider's 1 kHz output.
// Ports:
//   i_InitialSoc  2 MHz system clock. This is the only clock of the block.
//   i_rst_n       asynchronous active-low reset
//   i_clk_1k      1 kHz divided clock, sampled as data
//   bus           request/power-good inputs and registered sequencer outputs
module power_seq_ctrl
  import power_seq_ctrl_pkg::*;
#(
  parameter int N_RAIL     = 4,
  parameter int T_STEP_MS  = 10,
  parameter int T_PG_TO_MS = 50,
  parameter int T_RST_MS   = 100,
  parameter int CNT_W      = 8
) (
  input  logic             i_InitialSoc,
  input  logic             i_rst_n,
  input  logic             i_clk_1k,
  power_seq_ctrl_if.slave  bus
);

  localparam int IDX_W = (N_RAIL > 1) ? $clog2(N_RAIL) : 1;

  typedef logic [N_RAIL-1:0] rail_t;
  typedef logic [IDX_W-1:0]  idx_t;
  typedef logic [CNT_W-1:0]  cnt_t;

  localparam cnt_t T_STEP_C  = cnt_t'(T_STEP_MS);
  localparam cnt_t T_PG_TO_C = cnt_t'(T_PG_TO_MS);
  localparam cnt_t T_RST_C   = cnt_t'(T_RST_MS);
  localparam cnt_t CNT_MAX_C = '1;
  localparam idx_t IDX_LAST  = idx_t'(N_RAIL - 1);

  if ((N_RAIL < 1) || (N_RAIL > N_RAIL_MAX)) begin : g_bad_n_rail
    $error("power_seq_ctrl: N_RAIL must be in 1..8");
  end

  if (!cnt_w_fits(CNT_W, max3(T_STEP_MS, T_PG_TO_MS, T_RST_MS))) begin : g_bad_cnt_w
    $error("power_seq_ctrl: CNT_W too narrow for the longest delay");
  end

  state_e state_r;
  state_e next_state_s;
  idx_t   idx_r;
  idx_t   idx_nxt_s;
  cnt_t   timer_r;
  logic   timer_clr_s;
  logic   shut_step_s;
  logic   tick_s;

  rail_t  pg_meta_r;
  rail_t  pg_s_r;
  rail_t  pend_mask_s;
  logic   pg_lost_s;

  rail_t  rail_en_r;
  rail_t  rail_en_nxt_s;
  logic   sys_rst_n_r;
  logic   sys_rst_n_nxt_s;
  logic   pwr_ok_r;
  logic   pwr_ok_nxt_s;
  logic   fault_r;
  logic   fault_nxt_s;

  ms_tick_gen u_tick (
    .clk    (i_InitialSoc),
    .rst_n  (i_rst_n),
    .clk_1k (i_clk_1k),
    .tick   (tick_s)
  );

  // Two-flop synchronisers for the asynchronous power-good inputs.
  always_ff @(posedge i_InitialSoc or negedge i_rst_n) begin
    if (!i_rst_n) begin
      pg_meta_r <= '0;
      pg_s_r    <= '0;
    end else begin
      pg_meta_r <= bus.i_pg;
      pg_s_r    <= pg_meta_r;
    end
  end

  // PG loss means an enabled rail reports bad power. In WAIT_PG, the rail being
  // brought up has not yet reported good, so it is masked out.
  always_comb begin
    if (state_r == ST_WAIT_PG) begin
      pend_mask_s = rail_t'(1'b1) << idx_r;
    end else begin
      pend_mask_s = '0;
    end
    pg_lost_s = |(rail_en_r & ~pg_s_r & ~pend_mask_s);
  end

  // One power-down step completes each time the settle delay expires in SHUTDOWN.
  assign shut_step_s = (state_r == ST_SHUTDOWN) && (timer_r == T_STEP_C);

  // State and rail-index registers.
  always_ff @(posedge i_InitialSoc or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_r <= ST_IDLE;
      idx_r   <= '0;
    end else begin
      state_r <= next_state_s;
      idx_r   <= idx_nxt_s;
    end
  end

  // Next-state logic. Where events coincide, the priority is fault, then
  // power-off request, then normal advance.
  // When power is withdrawn during bring-up, idx_r already names the highest
  // enabled rail, so SHUTDOWN starts from idx_r unchanged.
  always_comb begin
    next_state_s = state_r;
    idx_nxt_s    = idx_r;
    case (state_r)
      ST_IDLE: begin
        if (bus.i_pwr_req) begin
          next_state_s = ST_ENABLE;
          idx_nxt_s    = '0;
        end else begin
          next_state_s = ST_IDLE;
        end
      end
      ST_ENABLE: begin
        if (!bus.i_pwr_req) begin
          next_state_s = ST_SHUTDOWN;
        end else begin
          next_state_s = ST_WAIT_PG;
        end
      end
      ST_WAIT_PG: begin
        if (pg_lost_s || (timer_r == T_PG_TO_C)) begin
          next_state_s = ST_FAULT;
        end else if (!bus.i_pwr_req) begin
          next_state_s = ST_SHUTDOWN;
        end else if (pg_s_r[idx_r]) begin
          if (idx_r == IDX_LAST) begin
            next_state_s = ST_HOLD_RST;
          end else begin
            next_state_s = ST_STEP;
          end
        end else begin
          next_state_s = ST_WAIT_PG;
        end
      end
      ST_STEP: begin
        if (pg_lost_s) begin
          next_state_s = ST_FAULT;
        end else if (!bus.i_pwr_req) begin
          next_state_s = ST_SHUTDOWN;
        end else if (timer_r == T_STEP_C) begin
          next_state_s = ST_ENABLE;
          idx_nxt_s    = idx_r + idx_t'(1'b1);
        end else begin
          next_state_s = ST_STEP;
        end
      end
      ST_HOLD_RST: begin
        if (pg_lost_s) begin
          next_state_s = ST_FAULT;
        end else if (!bus.i_pwr_req) begin
          next_state_s = ST_SHUTDOWN;
          idx_nxt_s    = IDX_LAST;
        end else if (timer_r == T_RST_C) begin
          next_state_s = ST_ON;
        end else begin
          next_state_s = ST_HOLD_RST;
        end
      end
      ST_ON: begin
        if (pg_lost_s) begin
          next_state_s = ST_FAULT;
        end else if (!bus.i_pwr_req) begin
          next_state_s = ST_SHUTDOWN;
          idx_nxt_s    = IDX_LAST;
        end else begin
          next_state_s = ST_ON;
        end
      end
      ST_SHUTDOWN: begin
        // In SHUTDOWN, power requests and PG loss are both ignored. The rails
        // always step all the way down.
        if (shut_step_s) begin
          if (idx_r == '0) begin
            next_state_s = ST_IDLE;
          end else begin
            next_state_s = ST_SHUTDOWN;
            idx_nxt_s    = idx_r - idx_t'(1'b1);
          end
        end else begin
          next_state_s = ST_SHUTDOWN;
        end
      end
      ST_FAULT: begin
        if (!bus.i_pwr_req) begin
          next_state_s = ST_IDLE;
          idx_nxt_s    = '0;
        end else begin
          next_state_s = ST_FAULT;
        end
      end
      default: begin
        next_state_s = ST_IDLE;
        idx_nxt_s    = '0;
      end
    endcase
  end

  // The ms timer restarts on every state entry and on each power-down step.
  assign timer_clr_s = (next_state_s != state_r) || shut_step_s;

  // The ms timer counts ticks and saturates at all-ones.
  always_ff @(posedge i_InitialSoc or negedge i_rst_n) begin
    if (!i_rst_n) begin
      timer_r <= '0;
    end else if (timer_clr_s) begin
      timer_r <= '0;
    end else if (tick_s && (timer_r != CNT_MAX_C)) begin
      timer_r <= timer_r + cnt_t'(1'b1);
    end else begin
      timer_r <= timer_r;
    end
  end

  // Output decode. It works from the next state, so the registered outputs
  // change on the same edge as the state register.
  always_comb begin
    rail_en_nxt_s   = rail_en_r;
    sys_rst_n_nxt_s = (next_state_s == ST_ON);
    pwr_ok_nxt_s    = (next_state_s == ST_ON);
    fault_nxt_s     = (next_state_s == ST_FAULT);
    case (next_state_s)
      ST_IDLE, ST_FAULT: begin
        rail_en_nxt_s = '0;
      end
      ST_ENABLE: begin
        rail_en_nxt_s = rail_en_r | (rail_t'(1'b1) << idx_nxt_s);
      end
      ST_SHUTDOWN: begin
        if (shut_step_s) begin
          rail_en_nxt_s = rail_en_r & ~(rail_t'(1'b1) << idx_r);
        end else begin
          rail_en_nxt_s = rail_en_r;
        end
      end
      default: begin
        rail_en_nxt_s = rail_en_r;
      end
    endcase
  end

  // Output registers. Reset forces every rail off at once.
  always_ff @(posedge i_InitialSoc or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rail_en_r   <= '0;
      sys_rst_n_r <= 1'b0;
      pwr_ok_r    <= 1'b0;
      fault_r     <= 1'b0;
    end else begin
      rail_en_r   <= rail_en_nxt_s;
      sys_rst_n_r <= sys_rst_n_nxt_s;
      pwr_ok_r    <= pwr_ok_nxt_s;
      fault_r     <= fault_nxt_s;
    end
  end

  assign bus.o_rail_en   = rail_en_r;
  assign bus.o_sys_rst_n = sys_rst_n_r;
  assign bus.o_pwr_ok    = pwr_ok_r;
  assign bus.o_fault     = fault_r;
  assign bus.o_state     = state_r;

endmodule

// File: tb/tb_power_seq_ctrl.sv
// Directed, self-checking bench for power_seq_ctrl.
// Parameters: N_RAIL=4, T_STEP_MS=2, T_PG_TO_MS=5, T_RST_MS=3.
// One "ms" is compressed to MS system-clock cycles. The DUT only counts edges of
// i_clk_1k, so this shortens the run without changing any behaviour.
module tb_power_seq_ctrl;
  import power_seq_ctrl_pkg::*;

  localparam int MS = 40;

  logic clk;
  logic rst_n;
  logic clk_1k;
  int   n_total;
  int   n_pass;
  int   n_fail;

  power_seq_ctrl_if #(.N_RAIL(4)) bus ();

  power_seq_ctrl #(
    .N_RAIL     (4),
    .T_STEP_MS  (2),
    .T_PG_TO_MS (5),
    .T_RST_MS   (3),
    .CNT_W      (8)
  ) dut (
    .i_InitialSoc (clk),
    .i_rst_n      (rst_n),
    .i_clk_1k     (clk_1k),
    .bus          (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial clk_1k = 1'b0;
  always #(MS * 5) clk_1k = ~clk_1k;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_range(input string tag, input int obs, input int lo, input int hi);
    n_total++;
    assert ((obs >= lo) && (obs <= hi)) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d cycles expected %0d..%0d", tag, obs, lo, hi);
    end
  endtask

  // Polls at negedges until o_rail_en matches, or until the budget expires.
  task automatic wait_en(input string tag, input logic [3:0] exp, input int budget, output int cyc);
    cyc = 0;
    while ((bus.o_rail_en !== exp) && (cyc < budget)) begin
      @(negedge clk);
      cyc++;
    end
    check(tag, 32'(bus.o_rail_en), 32'(exp));
  endtask

  task automatic wait_state(input string tag, input state_e exp, input int budget, output int cyc);
    cyc = 0;
    while ((bus.o_state !== exp) && (cyc < budget)) begin
      @(negedge clk);
      cyc++;
    end
    check(tag, 32'(bus.o_state), 32'(exp));
  endtask

  // Requests power. Each pg[k] rises 1 ms after en[k].
  task automatic bring_up(input bit wait_on);
    int cyc;
    bus.i_pwr_req = 1'b1;
    for (int k = 0; k < 4; k++) begin
      wait_en($sformatf("en_up%0d", k), 4'((1 << (k + 1)) - 1), 4 * MS, cyc);
      if (k > 0) check_range($sformatf("gap_up%0d", k), cyc + MS, 2 * MS, 3 * MS + 8);
      repeat (MS) @(negedge clk);
      bus.i_pg[k] = 1'b1;
    end
    if (wait_on) begin
      wait_state("reach_on", ST_ON, 5 * MS, cyc);
      check_range("rst_hold", cyc, 2 * MS, 3 * MS + 8);
      check("on_sys_rst_n", 32'(bus.o_sys_rst_n), 32'd1);
      check("on_pwr_ok", 32'(bus.o_pwr_ok), 32'd1);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int cyc;
    n_total = 0;
    n_pass  = 0;
    n_fail  = 0;
    rst_n         = 1'b0;
    bus.i_pwr_req = 1'b0;
    bus.i_pg      = 4'b0000;

    // Reset state
    #1;
    check("rst_en", 32'(bus.o_rail_en), 32'h0);
    check("rst_sys_rst_n", 32'(bus.o_sys_rst_n), 32'd0);
    check("rst_pwr_ok", 32'(bus.o_pwr_ok), 32'd0);
    check("rst_fault", 32'(bus.o_fault), 32'd0);
    check("rst_state", 32'(bus.o_state), 32'(ST_IDLE));
    repeat (4) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    check("idle_en", 32'(bus.o_rail_en), 32'h0);

    // 1: normal power-up
    bring_up(1'b1);

    // 2: normal power-down
    bus.i_pwr_req = 1'b0;
    @(negedge clk);
    check("dn_sys_rst_n", 32'(bus.o_sys_rst_n), 32'd0);
    check("dn_pwr_ok", 32'(bus.o_pwr_ok), 32'd0);
    check("dn_state", 32'(bus.o_state), 32'(ST_SHUTDOWN));
    check("dn_en_hold", 32'(bus.o_rail_en), 32'hf);
    wait_en("dn_en3", 4'b0111, 3 * MS, cyc);
    check_range("dn_gap3", cyc + 1, MS, 2 * MS + 4);
    wait_en("dn_en2", 4'b0011, 3 * MS, cyc);
    check_range("dn_gap2", cyc, MS, 2 * MS + 4);
    wait_en("dn_en1", 4'b0001, 3 * MS, cyc);
    check_range("dn_gap1", cyc, MS, 2 * MS + 4);
    wait_en("dn_en0", 4'b0000, 3 * MS, cyc);
    check_range("dn_gap0", cyc, MS, 2 * MS + 4);
    check("dn_idle", 32'(bus.o_state), 32'(ST_IDLE));
    check("dn_no_fault", 32'(bus.o_fault), 32'd0);
    bus.i_pg = 4'b0000;
    repeat (4) @(negedge clk);

    // 3: pg[2] never rises, so the PG wait times out
    bus.i_pwr_req = 1'b1;
    wait_en("to_en0", 4'b0001, 4 * MS, cyc);
    repeat (MS) @(negedge clk);
    bus.i_pg[0] = 1'b1;
    wait_en("to_en1", 4'b0011, 4 * MS, cyc);
    repeat (MS) @(negedge clk);
    bus.i_pg[1] = 1'b1;
    wait_en("to_en2", 4'b0111, 4 * MS, cyc);
    wait_state("to_fault_state", ST_FAULT, 8 * MS, cyc);
    check_range("to_latency", cyc, 4 * MS, 5 * MS + 4);
    check("to_en_off", 32'(bus.o_rail_en), 32'h0);
    check("to_fault", 32'(bus.o_fault), 32'd1);
    repeat (2 * MS) @(negedge clk);
    check("to_fault_held", 32'(bus.o_fault), 32'd1);
    bus.i_pwr_req = 1'b0;
    @(negedge clk);
    check("to_fault_clr", 32'(bus.o_fault), 32'd0);
    check("to_idle", 32'(bus.o_state), 32'(ST_IDLE));
    bus.i_pg = 4'b0000;
    repeat (4) @(negedge clk);

    // 4: PG loss while ON
    bring_up(1'b1);
    bus.i_pg[1] = 1'b0;
    cyc = 0;
    while ((bus.o_fault !== 1'b1) && (cyc < 6)) begin
      @(negedge clk);
      cyc++;
    end
    check_range("loss_latency", cyc, 1, 3);
    check("loss_en_off", 32'(bus.o_rail_en), 32'h0);
    check("loss_fault", 32'(bus.o_fault), 32'd1);
    check("loss_pwr_ok", 32'(bus.o_pwr_ok), 32'd0);
    bus.i_pwr_req = 1'b0;
    @(negedge clk);
    check("loss_fault_clr", 32'(bus.o_fault), 32'd0);
    bus.i_pg = 4'b0000;
    repeat (4) @(negedge clk);

    // 5: power withdrawn during bring-up, while en=0011
    bus.i_pwr_req = 1'b1;
    wait_en("ab_en0", 4'b0001, 4 * MS, cyc);
    repeat (MS) @(negedge clk);
    bus.i_pg[0] = 1'b1;
    wait_en("ab_en1", 4'b0011, 4 * MS, cyc);
    bus.i_pwr_req = 1'b0;
    @(negedge clk);
    check("ab_state", 32'(bus.o_state), 32'(ST_SHUTDOWN));
    bus.i_pwr_req = 1'b1;
    repeat (4) @(negedge clk);
    check("ab_ignore_req", 32'(bus.o_state), 32'(ST_SHUTDOWN));
    check("ab_en_hold", 32'(bus.o_rail_en), 32'h3);
    bus.i_pwr_req = 1'b0;
    wait_en("ab_en_dn1", 4'b0001, 3 * MS, cyc);
    check_range("ab_gap1", cyc + 4, MS, 2 * MS + 4);
    wait_en("ab_en_dn0", 4'b0000, 3 * MS, cyc);
    check_range("ab_gap0", cyc, MS, 2 * MS + 4);
    check("ab_idle", 32'(bus.o_state), 32'(ST_IDLE));
    check("ab_no_fault", 32'(bus.o_fault), 32'd0);
    bus.i_pg = 4'b0000;
    repeat (4) @(negedge clk);

    // 6: asynchronous reset while in HOLD_RST
    bring_up(1'b0);
    repeat (MS) @(negedge clk);
    check("hr_state", 32'(bus.o_state), 32'(ST_HOLD_RST));
    check("hr_en", 32'(bus.o_rail_en), 32'hf);
    #2;
    rst_n = 1'b0;
    #1;
    check("ar_en", 32'(bus.o_rail_en), 32'h0);
    check("ar_sys_rst_n", 32'(bus.o_sys_rst_n), 32'd0);
    check("ar_pwr_ok", 32'(bus.o_pwr_ok), 32'd0);
    check("ar_fault", 32'(bus.o_fault), 32'd0);
    check("ar_state", 32'(bus.o_state), 32'(ST_IDLE));
    bus.i_pwr_req = 1'b0;
    bus.i_pg      = 4'b0000;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("ar_idle_after", 32'(bus.o_state), 32'(ST_IDLE));
    bring_up(1'b1);
    check("ar_resequence_en", 32'(bus.o_rail_en), 32'hf);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
